// File: rtl/inv_mix_cols_seq.sv
// Iterative AES-128 InvMixColumns engine: accepts a 128-bit state, transforms
// COLS_PER_CYCLE columns per clock in place and holds the result until accepted.
module inv_mix_cols_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [127:0] in_state_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [127:0] out_state_o,
  output logic         busy_o
);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
    $error("inv_mix_cols_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Step wraps to 0 for CPC=4, which is exactly the counter behaviour wanted.
  localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  col;
  logic [31:0] work [4];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Multiply by 09/0B/0D/0E built from the x2, x4, x8 xtime chain.
  function automatic logic [7:0] mul_inv(input logic [7:0] a, input logic [1:0] sel);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (sel)
      2'd0:    return x8 ^ x4 ^ x2;
      2'd1:    return x8 ^ x2 ^ a;
      2'd2:    return x8 ^ x4 ^ a;
      default: return x8 ^ a;
    endcase
  endfunction

  function automatic logic [31:0] inv_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    {a0, a1, a2, a3} = w;
    b0 = mul_inv(a0, 2'd0) ^ mul_inv(a1, 2'd1) ^ mul_inv(a2, 2'd2) ^ mul_inv(a3, 2'd3);
    b1 = mul_inv(a0, 2'd3) ^ mul_inv(a1, 2'd0) ^ mul_inv(a2, 2'd1) ^ mul_inv(a3, 2'd2);
    b2 = mul_inv(a0, 2'd2) ^ mul_inv(a1, 2'd3) ^ mul_inv(a2, 2'd0) ^ mul_inv(a3, 2'd1);
    b3 = mul_inv(a0, 2'd1) ^ mul_inv(a1, 2'd2) ^ mul_inv(a2, 2'd3) ^ mul_inv(a3, 2'd0);
    return {b0, b1, b2, b3};
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      col         <= 2'd0;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      for (int c = 0; c < 4; c++) work[c] <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i && in_ready_o) begin
            for (int c = 0; c < 4; c++) work[c] <= in_state_i[127-32*c -: 32];
            col        <= 2'd0;
            state      <= BUSY;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end
        BUSY: begin
          for (int k = 0; k < COLS_PER_CYCLE; k++)
            work[col + 2'(k)] <= inv_col(work[col + 2'(k)]);
          col <= col + COL_STEP;
          if (col == LAST_COL) begin
            state       <= DONE;
            busy_o      <= 1'b0;
            out_valid_o <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state       <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          col         <= 2'd0;
          in_ready_o  <= 1'b1;
          out_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

  assign out_state_o = {work[0], work[1], work[2], work[3]};

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Bench for inv_mix_cols_seq: three instances (1, 2 and 4 columns per cycle)
// checked against a generic GF(2^8) matrix model and the forward MixColumns.
module tb_inv_mix_cols_seq;

  logic         clk;
  logic         rst       [3];
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic         busy      [3];

  int compared;
  int mismatched;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    inv_mix_cols_seq #(.COLS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : 4)) dut (
      .clk_i      (clk),
      .rst_i      (rst[g]),
      .in_valid_i (in_valid[g]),
      .in_ready_o (in_ready[g]),
      .in_state_i (in_state[g]),
      .out_valid_o(out_valid[g]),
      .out_ready_i(out_ready[g]),
      .out_state_o(out_state[g]),
      .busy_o     (busy[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpc_of(input int d);
    return (d == 0) ? 1 : (d == 1) ? 2 : 4;
  endfunction

  // Shift-and-add field multiply, independent of any xtime decomposition.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product on every column; inverse selects 0E 0B 0D 09.
  function automatic logic [127:0] model_mix(input logic [127:0] s, input bit inverse);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (inverse) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127-8*(4*c+j) -: 8]);
        r[127-8*(4*c+row) -: 8] = acc;
      end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a negedge with the DUT idle; returns just after a negedge, idle again.
  task automatic run_state(input int d, input logic [127:0] s, output logic [127:0] res, output int lat);
    int edges;
    compared++;
    if (in_ready[d] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL idle_ready dut%0d: in_ready=%b, want 1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_state[d] = s;
    @(posedge clk); edges = 1;
    @(negedge clk);
    compared++;
    if (busy[d] !== 1'b1 || in_ready[d] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL busy_flags dut%0d: busy=%b in_ready=%b, want 1/0", d, busy[d], in_ready[d]);
    end
    in_state[d] = rand128();
    while (out_valid[d] !== 1'b1 && edges < 20) begin
      @(posedge clk); edges++;
      @(negedge clk);
      in_state[d] = rand128();
    end
    in_valid[d] = 1'b0;
    compared++;
    if (out_valid[d] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL done_timeout dut%0d: out_valid=%b after %0d edges, want 1", d, out_valid[d], edges);
    end
    res = out_state[d];
    lat = edges;
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    compared++;
    if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL release dut%0d: out_valid=%b in_ready=%b, want 0/1", d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_state[d] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    for (int d = 0; d < 3; d++) begin
      compared++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || out_state[d] !== 128'h0) begin
        mismatched++;
        $display("[TB] FAIL reset_state dut%0d: ready=%b valid=%b busy=%b out=%h, want 1/0/0/0",
                 d, in_ready[d], out_valid[d], busy[d], out_state[d]);
      end
    end
  endtask

  task automatic test_vectors();
    logic [127:0] vin  [5];
    logic [127:0] vexp [5];
    logic [127:0] res;
    int lat;
    vin[0] = 128'h8E4DA1BC_9FDC589D_9FDC589D_9FDC589D; vexp[0] = 128'hDB135345_F20A225C_F20A225C_F20A225C;
    vin[1] = {16{8'hC6}};                            vexp[1] = {16{8'hC6}};
    vin[2] = {16{8'h01}};                            vexp[2] = {16{8'h01}};
    vin[3] = 128'h0;                                 vexp[3] = 128'h0;
    vin[4] = 128'hD5D5D7D6_4D7EBDF8_C6C6C6C6_01010101; vexp[4] = 128'hD4D4D4D5_2D26314C_C6C6C6C6_01010101;
    for (int d = 0; d < 3; d++)
      for (int v = 0; v < 5; v++) begin
        run_state(d, vin[v], res, lat);
        compared++;
        if (res !== vexp[v]) begin
          mismatched++;
          $display("[TB] FAIL vector%0d dut%0d: got %h, want %h", v, d, res, vexp[v]);
        end
        compared++;
        if (lat != 4 / cpc_of(d) + 1) begin
          mismatched++;
          $display("[TB] FAIL latency dut%0d: got %0d edges, want %0d", d, lat, 4 / cpc_of(d) + 1);
        end
      end
  endtask

  task automatic test_random_round_trip();
    logic [127:0] s, res;
    int lat;
    for (int d = 0; d < 3; d++)
      for (int n = 0; n < 1000; n++) begin
        s = rand128();
        run_state(d, s, res, lat);
        compared++;
        if (res !== model_mix(s, 1'b1)) begin
          mismatched++;
          $display("[TB] FAIL random_inv dut%0d: in %h got %h, want %h", d, s, res, model_mix(s, 1'b1));
        end
        compared++;
        if (model_mix(res, 1'b0) !== s) begin
          mismatched++;
          $display("[TB] FAIL round_trip dut%0d: mix_cols(%h)=%h, want %h", d, res, model_mix(res, 1'b0), s);
        end
      end
  endtask

  task automatic test_backpressure();
    logic [127:0] s, s2, exp1, res;
    int edges, lat;
    for (int d = 0; d < 3; d++) begin
      s = rand128(); s2 = rand128();
      exp1 = model_mix(s, 1'b1);
      in_valid[d] = 1'b1; in_state[d] = s;
      @(posedge clk); @(negedge clk);
      in_valid[d] = 1'b0;
      edges = 0;
      while (out_valid[d] !== 1'b1 && edges < 20) begin
        @(posedge clk); @(negedge clk); edges++;
      end
      for (int k = 0; k < 10; k++) begin
        in_valid[d] = 1'b1; in_state[d] = s2;
        @(posedge clk); @(negedge clk);
        compared++;
        if (out_valid[d] !== 1'b1 || in_ready[d] !== 1'b0 || out_state[d] !== exp1) begin
          mismatched++;
          $display("[TB] FAIL hold dut%0d cyc%0d: valid=%b ready=%b out=%h, want 1/0/%h",
                   d, k, out_valid[d], in_ready[d], out_state[d], exp1);
        end
      end
      out_ready[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready[d] = 1'b0;
      compared++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_release dut%0d: ready=%b valid=%b, want 1/0", d, in_ready[d], out_valid[d]);
      end
      @(posedge clk); @(negedge clk);
      in_valid[d] = 1'b0;
      compared++;
      if (busy[d] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL bp_accept dut%0d: busy=%b, want 1", d, busy[d]);
      end
      edges = 0;
      while (out_valid[d] !== 1'b1 && edges < 20) begin
        @(posedge clk); @(negedge clk); edges++;
      end
      compared++;
      if (out_valid[d] !== 1'b1 || out_state[d] !== model_mix(s2, 1'b1)) begin
        mismatched++;
        $display("[TB] FAIL bp_second dut%0d: valid=%b out=%h, want 1/%h", d, out_valid[d], out_state[d], model_mix(s2, 1'b1));
      end
      out_ready[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      out_ready[d] = 1'b0;
      run_state(d, s, res, lat);
      compared++;
      if (res !== exp1) begin
        mismatched++;
        $display("[TB] FAIL bp_after dut%0d: got %h, want %h", d, res, exp1);
      end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] s, s2, res;
    int lat, n;
    for (int d = 0; d < 3; d++) begin
      s = rand128() | 128'h1; s2 = rand128();
      n = (cpc_of(d) == 4) ? 0 : 2 / cpc_of(d);
      in_valid[d] = 1'b1; in_state[d] = s;
      @(posedge clk); @(negedge clk);
      in_valid[d] = 1'b0;
      repeat (n) begin @(posedge clk); @(negedge clk); end
      compared++;
      if (busy[d] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL mid_busy dut%0d: busy=%b, want 1", d, busy[d]);
      end
      rst[d] = 1'b1;
      @(posedge clk); @(negedge clk);
      rst[d] = 1'b0;
      compared++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 || out_state[d] !== 128'h0) begin
        mismatched++;
        $display("[TB] FAIL abort dut%0d: ready=%b valid=%b busy=%b out=%h, want 1/0/0/0",
                 d, in_ready[d], out_valid[d], busy[d], out_state[d]);
      end
      run_state(d, s2, res, lat);
      compared++;
      if (res !== model_mix(s2, 1'b1)) begin
        mismatched++;
        $display("[TB] FAIL post_abort dut%0d: got %h, want %h", d, res, model_mix(s2, 1'b1));
      end
    end
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_reset_mid_busy();
    test_random_round_trip();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
